led_pwm_multi: RTL and testbench

- Multi-channel LED driver and parametrised successor to the single-channel breathing LED block.
- Generates CH_NUM independent LED outputs. Each output runs in one of four modes: off, on, blink or breathe (triangle ramp).
- Duty resolution and step time are parametrised.
- Sits beside the status/heartbeat logic. Per-channel mode comes from a control register bus.

---
 rtl/led_pwm_multi.sv | 166 ++++++++++++++++
 tb/tb_led_pwm_multi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_multi.sv
// led_pwm_multi
//   Multi-channel LED driver. Each of CH_NUM outputs runs in one of four
//   modes (off / on / blink / breathe). Breathing follows a triangle ramp of
//   PWM duty, one level step per PWM frame. All channels share one tick
//   counter, one PWM counter and one blink counter, so blink channels stay
//   phase-aligned.
//
//   Optional build macro: LED_GAMMA_EN
//     defined   -> breath duty = (level*level) >> PWM_BITS (gamma ~2)
//     undefined -> breath duty = level (linear, no multiplier)
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   synchronous active-low reset
//   mode_in      in   [2*CH_NUM-1:0] per-channel mode, bits [2i+1:2i] = ch i
//                     00 off, 01 on, 10 blink, 11 breathe
//   led_out      out  [CH_NUM-1:0] registered LED drive
//   frame_pulse  out  one-cycle pulse after each PWM frame boundary
module led_pwm_multi #(
    parameter logic [31:0] CLK_FREQ        = 32'd50_000_000,
    parameter int unsigned CH_NUM          = 4,
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned TICK_US         = 4,
    parameter int unsigned BLINK_FRAMES    = 128,
    parameter logic        LED_VALID_LEVEL = 1'b0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [2*CH_NUM-1:0]   mode_in,
    output logic [CH_NUM-1:0]     led_out,
    output logic                  frame_pulse
);

    localparam logic [31:0] CNT_TICK_MAX = (CLK_FREQ / 32'd1_000_000) * TICK_US - 32'd1;
    localparam logic [PWM_BITS-1:0] MAXL = '1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_ON     = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_BREATH = 2'b11;

    logic [31:0]                     tick_cnt_q, tick_cnt_d;
    logic [PWM_BITS-1:0]             pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0]              blink_cnt_q, blink_cnt_d;
    logic                            blink_phase_q, blink_phase_d;
    logic [2*CH_NUM-1:0]             mode_q, mode_d;
    logic [CH_NUM-1:0][PWM_BITS-1:0] level_q, level_d;
    logic [CH_NUM-1:0]               dir_down_q, dir_down_d;
    logic [CH_NUM-1:0]               led_q, led_d;
    logic                            frame_pulse_q, frame_pulse_d;

    logic                            tick_end;
    logic                            frame_end;
    logic [PWM_BITS-1:0]             duty;
`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0]           level_sq;
`endif

    assign tick_end  = (tick_cnt_q == CNT_TICK_MAX);
    assign frame_end = tick_end && (pwm_cnt_q == MAXL);

    // Shared timebase: tick, PWM position, blink half-period and mode latch.
    always_comb begin
        tick_cnt_d    = tick_end ? '0 : tick_cnt_q + 32'd1;
        pwm_cnt_d     = pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        mode_d        = mode_q;
        frame_pulse_d = frame_end;
        if (tick_end) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end
        if (frame_end) begin
            mode_d = mode_in;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Breath level stepping. The decision uses the incoming mode (mode_in,
    // which becomes mode_q on this same edge) together with the outgoing
    // mode, so a channel entering breath always starts its first frame at 0.
    always_comb begin
        level_d    = level_q;
        dir_down_d = dir_down_q;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (frame_end) begin
                if ((mode_in[2*i +: 2] != MODE_BREATH) || (mode_q[2*i +: 2] != MODE_BREATH)) begin
                    level_d[i]    = '0;
                    dir_down_d[i] = 1'b0;
                end else if (!dir_down_q[i]) begin
                    if (level_q[i] == MAXL) begin
                        dir_down_d[i] = 1'b1;
                        level_d[i]    = MAXL - 1'b1;
                    end else begin
                        level_d[i] = level_q[i] + 1'b1;
                    end
                end else begin
                    if (level_q[i] == '0) begin
                        dir_down_d[i] = 1'b0;
                        level_d[i]    = PWM_BITS'(1);
                    end else begin
                        level_d[i] = level_q[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Output decode from the current registered state (one cycle latency).
    always_comb begin
        led_d = {CH_NUM{~LED_VALID_LEVEL}};
        duty  = '0;
`ifdef LED_GAMMA_EN
        level_sq = '0;
`endif
        for (int unsigned i = 0; i < CH_NUM; i++) begin
`ifdef LED_GAMMA_EN
            level_sq = {{PWM_BITS{1'b0}}, level_q[i]} * {{PWM_BITS{1'b0}}, level_q[i]};
            duty     = PWM_BITS'(level_sq >> PWM_BITS);
`else
            duty = level_q[i];
`endif
            case (mode_q[2*i +: 2])
                MODE_OFF:   led_d[i] = ~LED_VALID_LEVEL;
                MODE_ON:    led_d[i] = LED_VALID_LEVEL;
                MODE_BLINK: led_d[i] = blink_phase_q ? LED_VALID_LEVEL : ~LED_VALID_LEVEL;
                default:    led_d[i] = (pwm_cnt_q < duty) ? LED_VALID_LEVEL : ~LED_VALID_LEVEL;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tick_cnt_q    <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            mode_q        <= '0;
            level_q       <= '0;
            dir_down_q    <= '0;
            led_q         <= {CH_NUM{~LED_VALID_LEVEL}};
            frame_pulse_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            mode_q        <= mode_d;
            level_q       <= level_d;
            dir_down_q    <= dir_down_d;
            led_q         <= led_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    assign led_out     = led_q;
    assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_led_pwm_multi.sv
// tb_led_pwm_multi
//   Self-checking bench for led_pwm_multi with a 4-clock tick and a
//   16-tick (64-clock) frame. Per-frame lit counts are pushed to a queue when
//   a frame starts and popped when the frame has been observed.
//   Build with LED_GAMMA_EN defined to check the gamma duty mapping.
module tb_led_pwm_multi;

    localparam int CH    = 4;
    localparam int PB    = 4;
    localparam int MAXL  = 15;
    localparam int TICK  = 4;
    localparam int FRAME = 64;
    localparam int BF    = 2;

    logic           sys_clk   = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic [2*CH-1:0] mode_in  = '0;
    logic [CH-1:0]  led_out;
    logic           frame_pulse;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    // Bench view of the frame currently being observed.
    logic [2*CH-1:0] cur_mode;
    int              frame_idx;
    int              breath_n [CH];

    led_pwm_multi #(
        .CLK_FREQ        (32'd4_000_000),
        .CH_NUM          (4),
        .PWM_BITS        (4),
        .TICK_US         (1),
        .BLINK_FRAMES    (2),
        .LED_VALID_LEVEL (1'b0)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .mode_in     (mode_in),
        .led_out     (led_out),
        .frame_pulse (frame_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Triangle: n-th frame since entering breath -> 0,1..15,14..1,0,1..
    function automatic int tri_level(input int n);
        int p;
        p = n % (2 * MAXL);
        return (p <= MAXL) ? p : (2 * MAXL - p);
    endfunction

    function automatic int duty_of(input int lvl);
`ifdef LED_GAMMA_EN
        return (lvl * lvl) / (1 << PB);
`else
        return lvl;
`endif
    endfunction

    function automatic logic [1:0] ch_mode(input int ch);
        return cur_mode[2*ch +: 2];
    endfunction

    function automatic bit blink_on();
        return ((frame_idx / BF) % 2) == 1;
    endfunction

    function automatic int exp_lit(input int ch);
        case (ch_mode(ch))
            2'b00:   return 0;
            2'b01:   return FRAME;
            2'b10:   return blink_on() ? FRAME : 0;
            default: return TICK * duty_of(tri_level(breath_n[ch]));
        endcase
    endfunction

    // Sample j (1..64) of a frame shows the PWM position (j-1)/TICK.
    function automatic bit exp_on(input int ch, input int j);
        case (ch_mode(ch))
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return blink_on();
            default: return ((j - 1) / TICK) < duty_of(tri_level(breath_n[ch]));
        endcase
    endfunction

    task automatic model_reset();
        cur_mode  = '0;
        frame_idx = 0;
        for (int ch = 0; ch < CH; ch++) breath_n[ch] = 0;
    endtask

    task automatic model_next_frame();
        logic [2*CH-1:0] prev;
        prev      = cur_mode;
        cur_mode  = mode_in;
        frame_idx = frame_idx + 1;
        for (int ch = 0; ch < CH; ch++) begin
            if (cur_mode[2*ch +: 2] == 2'b11)
                breath_n[ch] = (prev[2*ch +: 2] == 2'b11) ? breath_n[ch] + 1 : 0;
        end
    endtask

    // Observe one whole frame starting at a frame boundary sample point.
    // Optionally changes mode_in at sample change_at to probe the latch.
    task automatic measure_frame(input string tag, input int change_at, input logic [2*CH-1:0] new_mode);
        int lit [CH];
        int shape_err;
        int early;
        int blink_diff;
        int e;
        bit on;
        for (int ch = 0; ch < CH; ch++) begin
            exp_q.push_back(exp_lit(ch));
            lit[ch] = 0;
        end
        shape_err  = 0;
        early      = 0;
        blink_diff = 0;
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge sys_clk);
            for (int ch = 0; ch < CH; ch++) begin
                on = (led_out[ch] === 1'b0);
                if (on) lit[ch]++;
                if (on != exp_on(ch, j)) shape_err++;
            end
            if (j < FRAME && frame_pulse !== 1'b0) early++;
            if (ch_mode(2) == 2'b10 && ch_mode(3) == 2'b10 && led_out[2] !== led_out[3]) blink_diff++;
            if (j == change_at) mode_in = new_mode;
        end
        tests++;
        if (frame_pulse !== 1'b1) begin
            fails++;
            $display("FAIL %s frame %0d pulse_at_boundary: got %b expected 1", tag, frame_idx, frame_pulse);
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL %s frame %0d pulse_inside_frame: got %0d cycles expected 0", tag, frame_idx, early);
        end
        tests++;
        if (shape_err !== 0) begin
            fails++;
            $display("FAIL %s frame %0d waveform: got %0d wrong samples expected 0", tag, frame_idx, shape_err);
        end
        if (ch_mode(2) == 2'b10 && ch_mode(3) == 2'b10) begin
            tests++;
            if (blink_diff !== 0) begin
                fails++;
                $display("FAIL %s frame %0d blink_align: got %0d differing samples expected 0", tag, frame_idx, blink_diff);
            end
        end
        for (int ch = 0; ch < CH; ch++) begin
            e = exp_q.pop_front();
            tests++;
            if (lit[ch] !== e) begin
                fails++;
                $display("FAIL %s frame %0d ch%0d lit_count: got %0d expected %0d", tag, frame_idx, ch, lit[ch], e);
            end
        end
        model_next_frame();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        mode_in   = 8'hFF;
        repeat (10) @(negedge sys_clk);
        tests++;
        if (led_out !== 4'b1111) begin
            fails++;
            $display("FAIL reset led_out: got %b expected 1111", led_out);
        end
        tests++;
        if (frame_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset frame_pulse: got %b expected 0", frame_pulse);
        end
        sys_rst_n = 1'b1;
        mode_in   = 8'h00;
        model_reset();
        measure_frame("reset_release", -1, '0);
    endtask

    task automatic test_mode_latch();
        // ch0 -> on at clock 20: the running frame must stay dark.
        measure_frame("latch_midframe", 20, 8'h01);
        measure_frame("latch_applied", -1, '0);
    endtask

    task automatic test_breath();
        mode_in = 8'h0D;
        measure_frame("breath_pending", -1, '0);
        for (int f = 0; f < 32; f++) measure_frame("breath", -1, '0);
    endtask

    task automatic test_restart();
        int guard;
        guard = 0;
        while (tri_level(breath_n[1]) != 9 && guard < 40) begin
            measure_frame("restart_seek", -1, '0);
            guard++;
        end
        tests++;
        if (guard >= 40) begin
            fails++;
            $display("FAIL restart seek_level9: got %0d frames expected < 40", guard);
        end
        mode_in = 8'h01;
        measure_frame("restart_level9", -1, '0);
        mode_in = 8'h0D;
        measure_frame("restart_off", -1, '0);
        for (int f = 0; f < 3; f++) measure_frame("restart_ramp", -1, '0);
    endtask

    task automatic test_blink();
        mode_in = 8'hAD;
        measure_frame("blink_pending", -1, '0);
        for (int f = 0; f < 6; f++) measure_frame("blink", -1, '0);
    endtask

    task automatic test_reset_midframe();
        repeat (30) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        tests++;
        if (led_out !== 4'b1111) begin
            fails++;
            $display("FAIL midreset led_out: got %b expected 1111", led_out);
        end
        tests++;
        if (frame_pulse !== 1'b0) begin
            fails++;
            $display("FAIL midreset frame_pulse: got %b expected 0", frame_pulse);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        measure_frame("midreset_release", -1, '0);
        for (int f = 0; f < 4; f++) measure_frame("midreset_after", -1, '0);
    endtask

    initial begin
        test_reset();
        test_mode_latch();
        test_breath();
        test_restart();
        test_blink();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
